// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - byte-serial N-byte add sequencer around an external 8-bit adder (optional SUB_EN)
// Define SUB_EN to let in_sub turn an operation into A-B (B inverted, carry-in forced to 1).
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_c,
  input  logic                  add_cout,
  input  logic                  add_sign,
  input  logic                  add_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  out_sign,
  output logic                  out_zero
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           cin_q;
  logic           carry_q;
  logic [IW-1:0]  idx;
  logic [W-1:0]   sum_q;
  logic [W-1:0]   sum_next;
  logic [W-1:0]   b_sel;
  logic           cin_sel;

  // Subtraction is A + ~B + 1, so only the latched operands change.
`ifdef SUB_EN
  always_comb begin
    b_sel   = in_sub ? ~in_b : in_b;
    cin_sel = in_sub ? 1'b1 : in_cin;
  end
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  always_comb begin
    b_sel   = in_b;
    cin_sel = in_cin;
  end
`endif

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[{idx, 3'b000} +: 8];
      add_b   = b_q[{idx, 3'b000} +: 8];
      add_cin = (idx == '0) ? cin_q : carry_q;
    end
  end

  // Result with the current adder byte merged in; the zero flag is taken from this on the last byte.
  always_comb begin
    sum_next = sum_q;
    if (state == RUN) begin
      sum_next[{idx, 3'b000} +: 8] = add_c;
    end
  end

  assign out_sum = sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      idx       <= '0;
      sum_q     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= in_a;
            b_q      <= b_sel;
            cin_q    <= cin_sel;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= add_cout;
          if (idx == LAST) begin
            out_cout  <= add_cout;
            out_ovf   <= add_ovf;
            out_sign  <= add_sign;
            out_zero  <= ~|sum_next;
            idx       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - directed bench for multibyte_add_seq with a behavioural 8-bit adder
module tb_multibyte_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_c;
  logic        add_cout;
  logic        add_sign;
  logic        add_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_sign;
  logic        out_zero;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  always #5 clk = ~clk;

  // External adder stage the sequencer drives.
  always_comb begin
    {add_cout, add_c} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    add_sign = add_c[7];
    add_ovf  = (add_a[7] == add_b[7]) && (add_c[7] != add_a[7]);
  end

  multibyte_add_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_c(add_c), .add_cout(add_cout), .add_sign(add_sign), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_sign(out_sign), .out_zero(out_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_5678;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_flags", {out_cout, out_ovf, out_sign, out_zero}, 0);
    check("rst_add_bus", {add_a, add_b, add_cin}, 0);

    // 0xFF + 1: carry from byte 0 into byte 1, latency 4
    start(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(lat);
    check("t1_latency", lat, 4);
    check("t1_sum", out_sum, 32'h0000_0100);
    check("t1_flags", {out_cout, out_ovf, out_sign, out_zero}, 4'b0000);
    consume();
    check("t1_post_valid", out_valid, 0);
    check("t1_post_ready", in_ready, 1);

    // Signed overflow into the sign bit
    start(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(lat);
    check("t2_sum", out_sum, 32'h8000_0000);
    check("t2_flags", {out_cout, out_ovf, out_sign, out_zero}, 4'b0110);

    // Hold in DONE with ignored in_valid pulses
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a     = 32'h0000_0055 + k;
      step();
      in_valid = 1'b0;
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_ready", in_ready, 0);
      check("t4_hold_sum", out_sum, 32'h8000_0000);
      check("t4_hold_flags", {out_cout, out_ovf, out_sign, out_zero}, 4'b0110);
    end
    consume();
    check("t4_idle_valid", out_valid, 0);
    check("t4_idle_ready", in_ready, 1);
    check("t4_idle_add_a", add_a, 0);
    check("t4_kept_sum", out_sum, 32'h8000_0000);

    // Carry ripple through every byte
    start(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    check("t3_b0_cin", add_cin, 1);
    check("t3_b0_a", add_a, 8'hFF);
    for (int k = 1; k < 4; k++) begin
      step();
      check("t3_ripple_cin", add_cin, 1);
      check("t3_ripple_a", add_a, 8'hFF);
    end
    step();
    check("t3_valid", out_valid, 1);
    check("t3_sum", out_sum, 32'h0000_0000);
    check("t3_flags", {out_cout, out_ovf, out_sign, out_zero}, 4'b1001);
    consume();

    // Reset while byte 2 is on the adder
    start(32'h1122_3344, 32'h0101_0101, 1'b0, 1'b0);
    step();
    step();
    check("t5_byte2_a", add_a, 8'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_ready", in_ready, 1);
    check("t5_valid", out_valid, 0);
    check("t5_sum", out_sum, 0);
    check("t5_flags", {out_cout, out_ovf, out_sign, out_zero}, 0);
    check("t5_add_bus", {add_a, add_b, add_cin}, 0);
    step();
    check("t5_still_idle", {out_valid, in_ready}, 2'b01);
    start(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done(lat);
    check("t5_latency", lat, 4);
    check("t5_sum", out_sum, 32'd7);
    consume();

    // Subtract request
    start(32'd5, 32'd7, 1'b0, 1'b1);
    wait_done(lat);
    check("t6_latency", lat, 4);
`ifdef SUB_EN
    check("t6_sum", out_sum, 32'hFFFF_FFFE);
    check("t6_flags", {out_cout, out_ovf, out_sign, out_zero}, 4'b0010);
`else
    check("t6_sum", out_sum, 32'h0000_000C);
    check("t6_flags", {out_cout, out_ovf, out_sign, out_zero}, 4'b0000);
`endif
    consume();
    check("t6_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
